// File: rtl/aes_cbc_block_packer_pkg.sv
// Shared widths, FSM encoding and keep-decoding helpers for the AES-CBC block packer.
package aes_cbc_pkg;

    localparam int AES_BLK_W     = 128;
    localparam int WORD_W        = 32;
    localparam int BYTES_PER_BLK = 16;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        OUT  = 2'd1,
        PAD  = 2'd2
    } state_t;

    function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
        return 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
    endfunction

    // Bytes must be contiguous from the earliest lane ([31:24]).
    function automatic logic keep_legal(input logic [3:0] keep);
        return (keep == 4'b1111) || (keep == 4'b1110) || (keep == 4'b1100) ||
               (keep == 4'b1000) || (keep == 4'b0000);
    endfunction

endpackage

// File: rtl/aes_cbc_block_packer_if.sv
// Word-in / block-out handshake bundle; master feeds words and consumes blocks.
interface aes_cbc_block_packer_if;
    import aes_cbc_pkg::*;

    logic [WORD_W-1:0]    in_data;
    logic [3:0]           in_keep;
    logic                 in_last;
    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] blk_data;
    logic                 blk_last;
    logic                 blk_valid;
    logic                 blk_ready;

    modport master (
        output in_data, in_keep, in_last, in_valid, blk_ready,
        input  in_ready, blk_data, blk_last, blk_valid
    );

    modport slave (
        input  in_data, in_keep, in_last, in_valid, blk_ready,
        output in_ready, blk_data, blk_last, blk_valid
    );

endinterface

// File: rtl/aes_cbc_block_packer_pkcs7_pad_fill.sv
// Fills bytes bcnt..15 of a partial block with the PKCS#7 pad value (or zero when padding is off).
// Purely combinational; a full block (bcnt=16) passes through unchanged.
module pkcs7_pad_fill
    import aes_cbc_pkg::*;
(
    input  logic [AES_BLK_W-1:0] blk_in,
    input  logic [4:0]           bcnt,
    input  logic                 pad_en,
    output logic [AES_BLK_W-1:0] blk_out
);

    logic [7:0] pad_byte;

    always_comb begin
        pad_byte = pad_en ? (8'd16 - {3'b000, bcnt}) : 8'h00;
        blk_out  = blk_in;
        for (int i = 0; i < BYTES_PER_BLK; i++) begin
            if (5'(i) >= bcnt) begin
                blk_out[AES_BLK_W-1-8*i -: 8] = pad_byte;
            end
        end
    end

endmodule

// File: rtl/aes_cbc_block_packer.sv
// Packs a 32-bit word stream into 128-bit AES plaintext blocks with optional PKCS#7 padding.
// Latency: block valid right after the edge accepting its completing word; at most one block per 5 cycles.
// Backpressure: no words accepted while a block is held; block register stable until blk_valid & blk_ready.
module aes_cbc_block_packer
    import aes_cbc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   pad_en,
    aes_cbc_block_packer_if.slave  bus,
    output logic [CNT_W-1:0]       blk_count,
    output logic                   err_keep
);

    state_t               state_q, state_d;
    logic [1:0]           widx_q;
    logic [4:0]           bcnt_q;
    logic                 pad_pending_q;
    logic                 pad_lat_q;
    logic                 msg_active_q;
    logic [AES_BLK_W-1:0] part_q;
    logic [AES_BLK_W-1:0] blk_data_q;
    logic                 blk_last_q;

    logic                 in_ready;
    logic                 blk_valid;
    logic                 accept;
    logic                 blk_hs;
    logic                 pad_eff;
    logic [3:0]           keep_eff;
    logic                 keep_err;
    logic [WORD_W-1:0]    word_m;
    logic [AES_BLK_W-1:0] part_nxt;
    logic [4:0]           bcnt_nxt;
    logic                 blk_done;
    logic                 more_pad;
    logic [AES_BLK_W-1:0] final_blk;

    assign accept  = bus.in_valid & in_ready;
    assign blk_hs  = blk_valid & bus.blk_ready;
    // pad_en is only honoured on the first word; later words use the latched copy.
    assign pad_eff = msg_active_q ? pad_lat_q : pad_en;

    always_comb begin
        keep_eff = 4'hF;
        keep_err = 1'b0;
        if (bus.in_last) begin
            keep_err = !keep_legal(bus.in_keep);
            keep_eff = keep_err ? 4'hF : bus.in_keep;
        end else begin
            keep_err = (bus.in_keep != 4'hF);
        end
        for (int b = 0; b < 4; b++) begin
            word_m[8*b +: 8] = keep_eff[b] ? bus.in_data[8*b +: 8] : 8'h00;
        end
        part_nxt = part_q;
        case (widx_q)
            2'd0:    part_nxt[127:96] = word_m;
            2'd1:    part_nxt[95:64]  = word_m;
            2'd2:    part_nxt[63:32]  = word_m;
            default: part_nxt[31:0]   = word_m;
        endcase
        bcnt_nxt = bcnt_q + {2'b00, keep_bytes(keep_eff)};
        blk_done = accept && (bus.in_last || (widx_q == 2'd3));
        more_pad = bus.in_last && pad_eff && (bcnt_nxt == 5'd16);
    end

    pkcs7_pad_fill u_pad_fill (
        .blk_in  (part_nxt),
        .bcnt    (bcnt_nxt),
        .pad_en  (pad_eff),
        .blk_out (final_blk)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FILL;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        blk_valid = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (blk_done) state_d = OUT;
            end
            OUT: begin
                blk_valid = 1'b1;
                if (blk_hs) state_d = pad_pending_q ? PAD : FILL;
            end
            PAD: begin
                blk_valid = 1'b1;
                if (blk_hs) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
        if (clear) state_d = FILL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            widx_q        <= '0;
            bcnt_q        <= '0;
            pad_pending_q <= 1'b0;
            pad_lat_q     <= 1'b0;
            msg_active_q  <= 1'b0;
            part_q        <= '0;
            blk_data_q    <= '0;
            blk_last_q    <= 1'b0;
            blk_count     <= '0;
            err_keep      <= 1'b0;
        end else if (clear) begin
            widx_q        <= '0;
            bcnt_q        <= '0;
            pad_pending_q <= 1'b0;
            pad_lat_q     <= 1'b0;
            msg_active_q  <= 1'b0;
            part_q        <= '0;
            blk_data_q    <= '0;
            blk_last_q    <= 1'b0;
            blk_count     <= '0;
            err_keep      <= 1'b0;
        end else begin
            if (accept) begin
                err_keep     <= err_keep | keep_err;
                msg_active_q <= !bus.in_last;
                if (!msg_active_q) pad_lat_q <= pad_en;
                if (blk_done) begin
                    blk_data_q    <= bus.in_last ? final_blk : part_nxt;
                    blk_last_q    <= bus.in_last && !more_pad;
                    pad_pending_q <= more_pad;
                    part_q        <= '0;
                    widx_q        <= '0;
                    bcnt_q        <= '0;
                end else begin
                    part_q <= part_nxt;
                    widx_q <= widx_q + 2'd1;
                    bcnt_q <= bcnt_nxt;
                end
            end
            if (blk_hs) begin
                blk_count <= blk_count + CNT_W'(1);
                // A full final block under padding is followed by a whole pad block.
                if (state_q == OUT && pad_pending_q) begin
                    blk_data_q    <= {BYTES_PER_BLK{8'h10}};
                    blk_last_q    <= 1'b1;
                    pad_pending_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.blk_valid = blk_valid;
    assign bus.blk_data  = blk_data_q;
    assign bus.blk_last  = blk_last_q;

endmodule

// File: tb/tb_aes_cbc_block_packer.sv
// Directed bench for aes_cbc_block_packer: packing, PKCS#7 padding, backpressure, keep errors, clear and reset.
module tb_aes_cbc_block_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        pad_en = 1'b0;
    logic [15:0] blk_count;
    logic        err_keep;
    int          vec = 0;
    int          miss = 0;

    aes_cbc_block_packer_if bus();

    aes_cbc_block_packer #(.CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .pad_en    (pad_en),
        .bus       (bus.slave),
        .blk_count (blk_count),
        .err_keep  (err_keep)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        @(negedge clk);
        bus.in_data = d; bus.in_keep = k; bus.in_last = l; bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        vec++;
        if (bus.in_ready !== 1'b1) begin miss++; $display("FAIL send_timeout in_ready=%b want 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic wait_blk(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.blk_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        vec++;
        if (bus.blk_valid !== 1'b1) begin miss++; $display("FAIL %s blk_timeout blk_valid=%b want 1", tag, bus.blk_valid); end
    endtask

    task automatic take_blk;
        @(negedge clk); bus.blk_ready = 1'b1;
        @(posedge clk); #1; bus.blk_ready = 1'b0;
    endtask

    task automatic do_clear;
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
    endtask

    task automatic send_std4;
        send_word(32'h00112233, 4'hF, 1'b0);
        send_word(32'h44556677, 4'hF, 1'b0);
        send_word(32'h8899AABB, 4'hF, 1'b0);
        send_word(32'hCCDDEEFF, 4'hF, 1'b1);
    endtask

    task automatic test_reset;
        #1;
        vec++; if (bus.in_ready !== 1'b1)  begin miss++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        vec++; if (bus.blk_valid !== 1'b0) begin miss++; $display("FAIL rst_blk_valid got %b want 0", bus.blk_valid); end
        vec++; if (bus.blk_data !== 128'h0) begin miss++; $display("FAIL rst_blk_data got %h want 0", bus.blk_data); end
        vec++; if (blk_count !== 16'd0)    begin miss++; $display("FAIL rst_count got %0d want 0", blk_count); end
        vec++; if (err_keep !== 1'b0)      begin miss++; $display("FAIL rst_err got %b want 0", err_keep); end
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic test_full_nopad;
        do_clear; pad_en = 1'b0;
        send_std4;
        wait_blk("nopad");
        vec++; if (bus.blk_data !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin miss++; $display("FAIL nopad_data got %h", bus.blk_data); end
        vec++; if (bus.blk_last !== 1'b1) begin miss++; $display("FAIL nopad_last got %b want 1", bus.blk_last); end
        vec++; if (bus.in_ready !== 1'b0) begin miss++; $display("FAIL nopad_in_ready got %b want 0", bus.in_ready); end
        vec++; if (blk_count !== 16'd0)   begin miss++; $display("FAIL nopad_count_pre got %0d want 0", blk_count); end
        take_blk;
        vec++; if (blk_count !== 16'd1)   begin miss++; $display("FAIL nopad_count got %0d want 1", blk_count); end
        vec++; if (bus.blk_valid !== 1'b0) begin miss++; $display("FAIL nopad_valid_after got %b want 0", bus.blk_valid); end
    endtask

    task automatic test_full_pad;
        do_clear; pad_en = 1'b1;
        send_word(32'h00112233, 4'hF, 1'b0);
        pad_en = 1'b0;
        send_word(32'h44556677, 4'hF, 1'b0);
        send_word(32'h8899AABB, 4'hF, 1'b0);
        send_word(32'hCCDDEEFF, 4'hF, 1'b1);
        wait_blk("pad_a");
        vec++; if (bus.blk_data !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin miss++; $display("FAIL pad_data0 got %h", bus.blk_data); end
        vec++; if (bus.blk_last !== 1'b0) begin miss++; $display("FAIL pad_last0 got %b want 0", bus.blk_last); end
        take_blk;
        wait_blk("pad_b");
        vec++; if (bus.blk_data !== {16{8'h10}}) begin miss++; $display("FAIL pad_data1 got %h want all 10", bus.blk_data); end
        vec++; if (bus.blk_last !== 1'b1) begin miss++; $display("FAIL pad_last1 got %b want 1", bus.blk_last); end
        take_blk;
        vec++; if (blk_count !== 16'd2)   begin miss++; $display("FAIL pad_count got %0d want 2", blk_count); end
        vec++; if (bus.blk_valid !== 1'b0) begin miss++; $display("FAIL pad_valid_after got %b want 0", bus.blk_valid); end
    endtask

    task automatic test_single_pad;
        do_clear; pad_en = 1'b1;
        send_word(32'h61626300, 4'b1110, 1'b1);
        wait_blk("single");
        vec++; if (bus.blk_data !== 128'h6162630D_0D0D0D0D_0D0D0D0D_0D0D0D0D) begin miss++; $display("FAIL single_data got %h", bus.blk_data); end
        vec++; if (bus.blk_last !== 1'b1) begin miss++; $display("FAIL single_last got %b want 1", bus.blk_last); end
        vec++; if (err_keep !== 1'b0)     begin miss++; $display("FAIL single_err got %b want 0", err_keep); end
        take_blk;
    endtask

    task automatic test_empty;
        do_clear; pad_en = 1'b1;
        send_word(32'h0, 4'b0000, 1'b1);
        wait_blk("empty_pad");
        vec++; if (bus.blk_data !== {16{8'h10}}) begin miss++; $display("FAIL empty_pad_data got %h", bus.blk_data); end
        vec++; if (bus.blk_last !== 1'b1) begin miss++; $display("FAIL empty_pad_last got %b want 1", bus.blk_last); end
        take_blk;
        pad_en = 1'b0;
        send_word(32'h12345678, 4'b0000, 1'b1);
        wait_blk("empty_nopad");
        vec++; if (bus.blk_data !== 128'h0) begin miss++; $display("FAIL empty_nopad_data got %h want 0", bus.blk_data); end
        vec++; if (bus.blk_last !== 1'b1) begin miss++; $display("FAIL empty_nopad_last got %b want 1", bus.blk_last); end
        take_blk;
        vec++; if (blk_count !== 16'd2)   begin miss++; $display("FAIL empty_count got %0d want 2", blk_count); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] exp_a;
        exp_a = 128'h11111111_22222222_33333333_44444444;
        do_clear; pad_en = 1'b0;
        send_word(32'h11111111, 4'hF, 1'b0);
        send_word(32'h22222222, 4'hF, 1'b0);
        send_word(32'h33333333, 4'hF, 1'b0);
        send_word(32'h44444444, 4'hF, 1'b1);
        wait_blk("bp");
        bus.in_data = 32'hDEADBEEF; bus.in_keep = 4'hF; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vec++; if (bus.blk_valid !== 1'b1) begin miss++; $display("FAIL bp_valid c%0d got %b want 1", c, bus.blk_valid); end
            vec++; if (bus.blk_data !== exp_a) begin miss++; $display("FAIL bp_data c%0d got %h want %h", c, bus.blk_data, exp_a); end
            vec++; if (bus.in_ready !== 1'b0)  begin miss++; $display("FAIL bp_in_ready c%0d got %b want 0", c, bus.in_ready); end
        end
        bus.blk_ready = 1'b1;
        @(posedge clk); #1; bus.blk_ready = 1'b0;
        @(posedge clk); #1; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        wait_blk("bp_next");
        vec++; if (bus.blk_data !== 128'hDEADBEEF_00000000_00000000_00000000) begin miss++; $display("FAIL bp_next_data got %h", bus.blk_data); end
        vec++; if (bus.blk_last !== 1'b1) begin miss++; $display("FAIL bp_next_last got %b want 1", bus.blk_last); end
        take_blk;
        vec++; if (blk_count !== 16'd2)   begin miss++; $display("FAIL bp_count got %0d want 2", blk_count); end
    endtask

    task automatic test_bad_keep;
        do_clear; pad_en = 1'b0;
        send_word(32'h01010101, 4'hF, 1'b1);
        wait_blk("bk_pre");
        take_blk;
        send_word(32'hAABBCCDD, 4'b1010, 1'b1);
        wait_blk("bk");
        vec++; if (err_keep !== 1'b1) begin miss++; $display("FAIL bk_err got %b want 1", err_keep); end
        vec++; if (bus.blk_data !== 128'hAABBCCDD_00000000_00000000_00000000) begin miss++; $display("FAIL bk_data got %h", bus.blk_data); end
        vec++; if (blk_count !== 16'd1) begin miss++; $display("FAIL bk_count_pre got %0d want 1", blk_count); end
        do_clear;
        vec++; if (err_keep !== 1'b0)      begin miss++; $display("FAIL clr_err got %b want 0", err_keep); end
        vec++; if (blk_count !== 16'd0)    begin miss++; $display("FAIL clr_count got %0d want 0", blk_count); end
        vec++; if (bus.blk_valid !== 1'b0) begin miss++; $display("FAIL clr_valid got %b want 0", bus.blk_valid); end
        vec++; if (bus.in_ready !== 1'b1)  begin miss++; $display("FAIL clr_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid;
        do_clear; pad_en = 1'b0;
        send_word(32'h01010101, 4'b1100, 1'b0);
        send_word(32'h55555555, 4'hF, 1'b1);
        wait_blk("rm_pre");
        take_blk;
        send_word(32'h99999999, 4'hF, 1'b0);
        send_word(32'h88888888, 4'hF, 1'b0);
        @(negedge clk); reset_n = 1'b0; #1;
        vec++; if (bus.in_ready !== 1'b1)  begin miss++; $display("FAIL rm_in_ready got %b want 1", bus.in_ready); end
        vec++; if (bus.blk_valid !== 1'b0) begin miss++; $display("FAIL rm_valid got %b want 0", bus.blk_valid); end
        vec++; if (bus.blk_data !== 128'h0) begin miss++; $display("FAIL rm_data got %h want 0", bus.blk_data); end
        vec++; if (blk_count !== 16'd0)    begin miss++; $display("FAIL rm_count got %0d want 0", blk_count); end
        vec++; if (err_keep !== 1'b0)      begin miss++; $display("FAIL rm_err got %b want 0", err_keep); end
        @(negedge clk); reset_n = 1'b1;
        send_word(32'h0A0B0C0D, 4'hF, 1'b0);
        send_word(32'h1A1B1C1D, 4'hF, 1'b0);
        send_word(32'h2A2B2C2D, 4'hF, 1'b0);
        send_word(32'h3A3B3C3D, 4'hF, 1'b1);
        wait_blk("rm_post");
        vec++; if (bus.blk_data !== 128'h0A0B0C0D_1A1B1C1D_2A2B2C2D_3A3B3C3D) begin miss++; $display("FAIL rm_post_data got %h", bus.blk_data); end
        vec++; if (bus.blk_last !== 1'b1) begin miss++; $display("FAIL rm_post_last got %b want 1", bus.blk_last); end
        take_blk;
        vec++; if (blk_count !== 16'd1)   begin miss++; $display("FAIL rm_post_count got %0d want 1", blk_count); end
    endtask

    initial begin
        bus.in_data = '0; bus.in_keep = '0; bus.in_last = 1'b0;
        bus.in_valid = 1'b0; bus.blk_ready = 1'b0;
        test_reset;
        test_full_nopad;
        test_full_pad;
        test_single_pad;
        test_empty;
        test_back_to_back;
        test_bad_keep;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/aes_cbc_block_packer.md
Name: aes_cbc_block_packer

Overview:
- Upstream feeder for the AES-CBC stage: accepts a 32-bit word stream with valid/ready handshake.
- Packs the words into 128-bit plaintext blocks, byte 0 at [127:120].
- Optionally applies PKCS#7 padding to the final block of each message.
- Presents blocks with valid/ready and a last flag to the CBC encrypt wrapper.

Parameters:
- CNT_W, 16, width of the emitted-block counter (wraps).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush: drops partial and held blocks, clears counter and error.
- pad_en  input  1  PKCS#7 enable; sampled on the first accepted word of a message.
- in_data  input  32  word; byte at [31:24] is earliest in the stream.
- in_keep  input  4  byte enables; bit3 = [31:24]; meaningful only with in_last.
- in_last  input  1  final word of the message.
- in_valid  input  1  word present.
- in_ready  output  1  word accepted when in_valid & in_ready.
- blk_data  output  128  packed/padded plaintext block.
- blk_last  output  1  final block of the message.
- blk_valid  output  1  block held.
- blk_ready  input  1  consumer accepts; handshake = blk_valid & blk_ready.
- blk_count  output  CNT_W  blocks emitted since reset/clear.
- err_keep  output  1  sticky flag for an illegal keep pattern.

Behaviour:
- Reset (async): state FILL, word index 0, byte count 0, pad_pending 0.
  - All outputs 0 except in_ready=1.
  - Reset mid-message discards everything.
- States:
  - FILL: in_ready=1, blk_valid=0.
  - OUT: in_ready=0, blk_valid=1; output register stable until handshake.
  - PAD: in_ready=0, blk_valid=1, blk_data = 16 × 8'h10, blk_last=1.
- FILL, per accepted word:
  - Write the word to slot widx: widx0 → [127:96], widx3 → [31:0].
  - Add the valid-byte count to bcnt (0..16) and increment widx.
- Keep rules:
  - Non-last words: keep is treated as 4'b1111.
  - Last word: legal patterns are 1111, 1110, 1100, 1000 and 0000.
  - An illegal pattern on the last word sets err_keep and is treated as 1111.
  - A non-last word with keep≠1111 also sets err_keep.
  - Disabled bytes in a word are forced to 0.
- FILL→OUT, in the cycle after the accepting edge:
  - Condition: widx reaches 4, or in_last is accepted.
  - Latency: the completing word is accepted at edge N; blk_valid=1 from edge N.
- Final block content when in_last is accepted:
  - Case bcnt<16 and pad_en latched: bytes bcnt..15 = 16-bcnt (PKCS#7); blk_last=1.
  - Case bcnt<16 and pad_en=0: remaining bytes 0; blk_last=1.
  - Case bcnt=16 and pad_en: blk_last=0, set pad_pending.
  - Case bcnt=16 and pad_en=0: blk_last=1.
- Empty message (first word has in_last with keep 0000):
  - With pad_en: one block of all 8'h10, blk_last=1.
  - Without pad_en: one zero block, blk_last=1.
- OUT, on handshake:
  - If pad_pending → PAD; otherwise → FILL with widx=0, bcnt=0.
  - blk_count increments.
- PAD, on handshake: → FILL, pad_pending=0, blk_count increments.
- blk_count wraps modulo 2^CNT_W.
- Throughput: at most one block per 5 cycles. There is no word acceptance while a block is held (no skid).
- clear: highest priority; takes effect at the next edge even during a handshake.
  - State returns to FILL with blk_valid=0.
  - blk_count, err_keep, widx, bcnt and pad_pending all return to 0.
  - A handshake in the clear cycle does not increment the counter.
- blk_ready held high with blk_valid low has no effect.
- in_valid while in_ready=0 is ignored; the upstream source must hold the word.

Decomposition:
- Package aes_cbc_pkg holds:
  - AES_BLK_W=128, WORD_W=32, BYTES_PER_BLK=16.
  - State enum {FILL, OUT, PAD}.
  - Keep-to-byte-count function.
  - Legal-keep check function.
- One combinational sub-module, pkcs7_pad_fill:
  - Inputs: 128-bit partial block, bcnt[4:0], pad_en.
  - Output: final block.
  - Used for the last-block assembly.

Test Plan:
- 4 words 00112233, 44556677, 8899AABB, CCDDEEFF, last on word 4, pad_en=0 → one block 00112233_44556677_8899AABB_CCDDEEFF; blk_last=1; blk_count=1.
- Same stream with pad_en=1 → data block with blk_last=0, then block 10101010…10 with blk_last=1; blk_count=2.
- Single word 61626300, keep=1110, last, pad_en=1 → block 616263 followed by thirteen 0D bytes; blk_last=1.
- Hold blk_ready=0 for 10 cycles after the block appears → blk_data and blk_valid stable, in_ready=0, in_valid words not consumed; release → block accepted, next block correct.
- Last word with keep=1010 → err_keep=1, word treated as full; assert clear → err_keep=0, blk_count=0, blk_valid=0.
- Drop reset_n after 2 words → outputs 0, in_ready=1; new 4-word message packs from slot 0 correctly.
